// File: rtl/branch_redirect_ctrl_if.sv
// Signal bundle between the EX-stage pipeline and the branch redirect controller.
// master drives EX operands and fetch/memory status; slave is the controller.
interface branch_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic [2:0]       branch_sel;
  logic             eq;
  logic             lt;
  logic             ltu;
  logic [31:0]      target;
  logic             fetch_busy;
  logic             mem_stall;
  logic             cnt_clr;
  logic             pc_sel;
  logic [31:0]      pc_target;
  logic             flush_ifid;
  logic             flush_idex;
  logic             stall_req;
  logic             misalign;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output ex_valid, branch_sel, eq, lt, ltu, target, fetch_busy, mem_stall, cnt_clr,
    input  pc_sel, pc_target, flush_ifid, flush_idex, stall_req, misalign, br_cnt, taken_cnt
  );

  modport slave (
    input  ex_valid, branch_sel, eq, lt, ltu, target, fetch_busy, mem_stall, cnt_clr,
    output pc_sel, pc_target, flush_ifid, flush_idex, stall_req, misalign, br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolver: issues a one-cycle registered PC redirect, flushes the
// wrong-path stages, holds the target while fetch is busy, and counts branches.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_redirect_ctrl_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;

  state_t           state, state_next;
  logic             pc_sel, pc_sel_next;
  logic [31:0]      pc_target, pc_target_next;
  logic [31:0]      held_target, held_target_next;
  logic             flush, flush_next;
  logic             misalign, misalign_next;
  logic [FC_W-1:0]  flush_cnt, flush_cnt_next;
  logic [CNT_W-1:0] br_cnt, taken_cnt;
  logic             taken, resolve, aligned, is_cond;

  always_comb begin
    taken = 1'b0;
    case (bus.branch_sel)
      3'd1:    taken = bus.eq;
      3'd2:    taken = !bus.eq;
      3'd3:    taken = bus.lt;
      3'd4:    taken = !bus.lt;
      3'd5:    taken = bus.ltu;
      3'd6:    taken = !bus.ltu;
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign aligned = (bus.target[1:0] == 2'b00);
  assign is_cond = (bus.branch_sel != 3'd0) && (bus.branch_sel != 3'd7);
  assign resolve = bus.ex_valid && !bus.mem_stall && (state == IDLE) && (bus.branch_sel != 3'd0);

  always_comb begin
    state_next       = state;
    pc_sel_next      = 1'b0;
    pc_target_next   = pc_target;
    held_target_next = held_target;
    flush_next       = 1'b0;
    misalign_next    = 1'b0;
    flush_cnt_next   = flush_cnt;
    case (state)
      IDLE: begin
        if (resolve && taken) begin
          if (!aligned) begin
            misalign_next = 1'b1;
          end else if (!bus.fetch_busy) begin
            pc_sel_next    = 1'b1;
            pc_target_next = bus.target;
            flush_next     = 1'b1;
            flush_cnt_next = FC_LOAD;
            state_next     = FLUSH;
          end else begin
            held_target_next = bus.target;
            state_next       = PENDING;
          end
        end
      end
      PENDING: begin
        if (!bus.fetch_busy) begin
          pc_sel_next    = 1'b1;
          pc_target_next = held_target;
          flush_next     = 1'b1;
          flush_cnt_next = FC_LOAD;
          state_next     = FLUSH;
        end
      end
      FLUSH: begin
        // A frozen pipeline keeps the wrong-path instructions in place, so the count waits.
        flush_next = 1'b1;
        if (!bus.mem_stall) begin
          if (flush_cnt == '0) begin
            flush_next = 1'b0;
            state_next = IDLE;
          end else begin
            flush_cnt_next = flush_cnt - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_sel      <= 1'b0;
      pc_target   <= '0;
      held_target <= '0;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_next;
      pc_sel      <= pc_sel_next;
      pc_target   <= pc_target_next;
      held_target <= held_target_next;
      flush       <= flush_next;
      misalign    <= misalign_next;
      flush_cnt   <= flush_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (bus.cnt_clr) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (resolve && is_cond) begin
      if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (taken && (taken_cnt != '1)) taken_cnt <= taken_cnt + 1'b1;
    end
  end

  assign bus.stall_req  = rst_n && ((state == PENDING) ||
                                    (resolve && taken && aligned && bus.fetch_busy));
  assign bus.pc_sel     = pc_sel;
  assign bus.pc_target  = pc_target;
  assign bus.flush_ifid = flush;
  assign bus.flush_idex = flush;
  assign bus.misalign   = misalign;
  assign bus.br_cnt     = br_cnt;
  assign bus.taken_cnt  = taken_cnt;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: a vector table checked through an expectation queue,
// followed by hand-written fetch-busy, memory-stall, saturation, reset and clear sequences.
module tb_branch_redirect_ctrl;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  branch_redirect_ctrl_if #(.CNT_W(CW)) bus ();
  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // flags = {eq,lt,ltu}; ctl = {fetch_busy,mem_stall,cnt_clr}; xf = {stall,pc_sel,flush,misalign}
  typedef struct {
    logic          ev;
    logic [2:0]    sel;
    logic [2:0]    flags;
    logic [31:0]   tgt;
    logic [2:0]    ctl;
    logic [3:0]    xf;
    logic [31:0]   x_tgt;
    logic [CW-1:0] x_br;
    logic [CW-1:0] x_tk;
  } vec_t;

  typedef struct {
    logic          pcsel;
    logic [31:0]   tgt;
    logic          flush;
    logic          mis;
    logic [CW-1:0] br;
    logic [CW-1:0] tk;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  function automatic vec_t v(input logic ev, input logic [2:0] sel, input logic [2:0] flags,
                             input logic [31:0] tgt, input logic [2:0] ctl, input logic [3:0] xf,
                             input logic [31:0] x_tgt, input logic [CW-1:0] x_br,
                             input logic [CW-1:0] x_tk);
    vec_t r;
    r.ev = ev; r.sel = sel; r.flags = flags; r.tgt = tgt; r.ctl = ctl;
    r.xf = xf; r.x_tgt = x_tgt; r.x_br = x_br; r.x_tk = x_tk;
    return r;
  endfunction

  function automatic exp_t mk(input logic pcsel, input logic [31:0] tgt, input logic flush,
                              input logic mis, input logic [CW-1:0] br, input logic [CW-1:0] tk);
    exp_t e;
    e.pcsel = pcsel; e.tgt = tgt; e.flush = flush; e.mis = mis; e.br = br; e.tk = tk;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input exp_t e);
    check({tag, " pc_sel"},     32'(bus.pc_sel),     32'(e.pcsel));
    check({tag, " pc_target"},  bus.pc_target,       e.tgt);
    check({tag, " flush_ifid"}, 32'(bus.flush_ifid), 32'(e.flush));
    check({tag, " flush_idex"}, 32'(bus.flush_idex), 32'(e.flush));
    check({tag, " misalign"},   32'(bus.misalign),   32'(e.mis));
    check({tag, " br_cnt"},     32'(bus.br_cnt),     32'(e.br));
    check({tag, " taken_cnt"},  32'(bus.taken_cnt),  32'(e.tk));
  endtask

  task automatic drive(input logic ev, input logic [2:0] sel, input logic [2:0] flags,
                       input logic [31:0] tgt, input logic [2:0] ctl);
    bus.ex_valid   = ev;
    bus.branch_sel = sel;
    {bus.eq, bus.lt, bus.ltu} = flags;
    bus.target     = tgt;
    {bus.fetch_busy, bus.mem_stall, bus.cnt_clr} = ctl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    #1 check({tag, " stall_req"}, 32'(bus.stall_req), 32'(exp));
  endtask

  initial begin
    exp_t e;

    vecs[0]  = v(1'b1, 3'd1, 3'b100, 32'h100, 3'b000, 4'b0110, 32'h100, 8'd1, 8'd1);
    vecs[1]  = v(1'b0, 3'd0, 3'b000, 32'h0,   3'b000, 4'b0010, 32'h100, 8'd1, 8'd1);
    vecs[2]  = v(1'b1, 3'd1, 3'b100, 32'h300, 3'b000, 4'b0000, 32'h100, 8'd1, 8'd1);
    vecs[3]  = v(1'b1, 3'd4, 3'b010, 32'h400, 3'b000, 4'b0000, 32'h100, 8'd2, 8'd1);
    vecs[4]  = v(1'b1, 3'd7, 3'b000, 32'h500, 3'b000, 4'b0110, 32'h500, 8'd2, 8'd1);
    vecs[5]  = v(1'b0, 3'd0, 3'b000, 32'h0,   3'b000, 4'b0010, 32'h500, 8'd2, 8'd1);
    vecs[6]  = v(1'b0, 3'd0, 3'b000, 32'h0,   3'b000, 4'b0000, 32'h500, 8'd2, 8'd1);
    vecs[7]  = v(1'b1, 3'd2, 3'b000, 32'h102, 3'b000, 4'b0001, 32'h500, 8'd3, 8'd2);
    vecs[8]  = v(1'b0, 3'd0, 3'b000, 32'h0,   3'b000, 4'b0000, 32'h500, 8'd3, 8'd2);
    vecs[9]  = v(1'b0, 3'd3, 3'b010, 32'h600, 3'b000, 4'b0000, 32'h500, 8'd3, 8'd2);
    vecs[10] = v(1'b1, 3'd5, 3'b001, 32'h604, 3'b000, 4'b0110, 32'h604, 8'd4, 8'd3);
    vecs[11] = v(1'b0, 3'd0, 3'b000, 32'h0,   3'b000, 4'b0010, 32'h604, 8'd4, 8'd3);
    vecs[12] = v(1'b0, 3'd0, 3'b000, 32'h0,   3'b000, 4'b0000, 32'h604, 8'd4, 8'd3);
    vecs[13] = v(1'b1, 3'd6, 3'b001, 32'h608, 3'b000, 4'b0000, 32'h604, 8'd5, 8'd3);
    vecs[14] = v(1'b1, 3'd1, 3'b000, 32'h60C, 3'b000, 4'b0000, 32'h604, 8'd6, 8'd3);
    vecs[15] = v(1'b1, 3'd1, 3'b000, 32'h610, 3'b001, 4'b0000, 32'h604, 8'd0, 8'd0);

    // Reset with a taken, fetch-blocked jump on the inputs: stall must still stay low.
    rst_n = 1'b0;
    drive(1'b1, 3'd7, 3'b000, 32'h100, 3'b100);
    #2;
    check("reset stall_req", 32'(bus.stall_req), 32'd0);
    check_output("reset", mk(1'b0, 32'h0, 1'b0, 1'b0, 8'd0, 8'd0));
    @(negedge clk);
    drive(1'b0, 3'd0, 3'b000, 32'h0, 3'b000);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].ev, vecs[i].sel, vecs[i].flags, vecs[i].tgt, vecs[i].ctl);
      check_stall($sformatf("vec%0d", i), vecs[i].xf[3]);
      sb.push_back(mk(vecs[i].xf[2], vecs[i].x_tgt, vecs[i].xf[1], vecs[i].xf[0],
                      vecs[i].x_br, vecs[i].x_tk));
      tick();
      e = sb.pop_front();
      check_output($sformatf("vec%0d", i), e);
    end

    // Fetch busy for three cycles; branch inputs during PENDING must be ignored.
    drive(1'b1, 3'd7, 3'b000, 32'h200, 3'b100);
    check_stall("busy T", 1'b1);
    tick(); check_output("busy T", mk(1'b0, 32'h604, 1'b0, 1'b0, 8'd0, 8'd0));
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'd1, 3'b100, 32'h998, (i < 3) ? 3'b100 : 3'b000);
      check_stall($sformatf("busy T+%0d", i), 1'b1);
      tick();
      e = (i < 3) ? mk(1'b0, 32'h604, 1'b0, 1'b0, 8'd0, 8'd0)
                  : mk(1'b1, 32'h200, 1'b1, 1'b0, 8'd0, 8'd0);
      check_output($sformatf("busy T+%0d", i), e);
    end
    drive(1'b0, 3'd0, 3'b000, 32'h0, 3'b000);
    check_stall("busy T+4", 1'b0);
    tick(); check_output("busy T+4", mk(1'b0, 32'h200, 1'b1, 1'b0, 8'd0, 8'd0));
    tick(); check_output("busy T+5", mk(1'b0, 32'h200, 1'b0, 1'b0, 8'd0, 8'd0));

    // Not-taken branch held by a memory stall resolves exactly once.
    drive(1'b1, 3'd1, 3'b000, 32'h700, 3'b010);
    tick(); check_output("mstall hold1", mk(1'b0, 32'h200, 1'b0, 1'b0, 8'd0, 8'd0));
    tick(); check_output("mstall hold2", mk(1'b0, 32'h200, 1'b0, 1'b0, 8'd0, 8'd0));
    drive(1'b1, 3'd1, 3'b000, 32'h700, 3'b000);
    tick(); check_output("mstall release", mk(1'b0, 32'h200, 1'b0, 1'b0, 8'd1, 8'd0));

    // Taken branch held by a stall, then a stall during FLUSH stretches the flush window.
    drive(1'b1, 3'd1, 3'b100, 32'h710, 3'b010);
    tick(); check_output("flushstall T-1", mk(1'b0, 32'h200, 1'b0, 1'b0, 8'd1, 8'd0));
    drive(1'b1, 3'd1, 3'b100, 32'h710, 3'b000);
    tick(); check_output("flushstall T", mk(1'b1, 32'h710, 1'b1, 1'b0, 8'd2, 8'd1));
    for (int i = 1; i <= 4; i++) begin
      drive((i < 4) ? 1'b1 : 1'b0, 3'd1, 3'b100, 32'h710, (i <= 2) ? 3'b010 : 3'b000);
      tick();
      check_output($sformatf("flushstall T+%0d", i),
                   mk(1'b0, 32'h710, (i < 4) ? 1'b1 : 1'b0, 1'b0, 8'd2, 8'd1));
    end

    // Fetch becomes ready in the same cycle a memory stall begins.
    drive(1'b1, 3'd7, 3'b000, 32'h800, 3'b100);
    tick(); check_output("pend+ms T", mk(1'b0, 32'h710, 1'b0, 1'b0, 8'd2, 8'd1));
    drive(1'b0, 3'd0, 3'b000, 32'h0, 3'b010);
    check_stall("pend+ms T+1", 1'b1);
    tick(); check_output("pend+ms T+1", mk(1'b1, 32'h800, 1'b1, 1'b0, 8'd2, 8'd1));
    tick(); check_output("pend+ms T+2", mk(1'b0, 32'h800, 1'b1, 1'b0, 8'd2, 8'd1));
    drive(1'b0, 3'd0, 3'b000, 32'h0, 3'b000);
    tick(); check_output("pend+ms T+3", mk(1'b0, 32'h800, 1'b1, 1'b0, 8'd2, 8'd1));
    tick(); check_output("pend+ms T+4", mk(1'b0, 32'h800, 1'b0, 1'b0, 8'd2, 8'd1));

    // Back-to-back misaligned taken BEQs drive both counters into saturation.
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 3'd1, 3'b100, 32'h2, 3'b000);
      tick();
    end
    check_output("saturate", mk(1'b0, 32'h800, 1'b0, 1'b1, 8'hFF, 8'hFF));
    drive(1'b0, 3'd0, 3'b000, 32'h0, 3'b000);
    tick(); check_output("saturate idle", mk(1'b0, 32'h800, 1'b0, 1'b0, 8'hFF, 8'hFF));

    // Asynchronous reset while PENDING.
    drive(1'b1, 3'd7, 3'b000, 32'h900, 3'b100);
    tick();
    check_stall("pend reset pre", 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("pend reset stall_req", 32'(bus.stall_req), 32'd0);
    check_output("pend reset", mk(1'b0, 32'h0, 1'b0, 1'b0, 8'd0, 8'd0));
    drive(1'b0, 3'd0, 3'b000, 32'h0, 3'b100);
    #2 rst_n = 1'b1;
    check_stall("post reset", 1'b0);
    tick(); check_output("post reset", mk(1'b0, 32'h0, 1'b0, 1'b0, 8'd0, 8'd0));
    check("post reset stall_req", 32'(bus.stall_req), 32'd0);

    // Clear beats a simultaneous increment; the redirect itself still happens.
    drive(1'b1, 3'd2, 3'b100, 32'hA00, 3'b000);
    tick(); check_output("clr pre", mk(1'b0, 32'h0, 1'b0, 1'b0, 8'd1, 8'd0));
    drive(1'b1, 3'd2, 3'b000, 32'hA00, 3'b001);
    tick(); check_output("clr", mk(1'b1, 32'hA00, 1'b1, 1'b0, 8'd0, 8'd0));
    drive(1'b0, 3'd0, 3'b000, 32'h0, 3'b000);
    tick(); check_output("clr T+2", mk(1'b0, 32'hA00, 1'b1, 1'b0, 8'd0, 8'd0));
    tick(); check_output("clr T+3", mk(1'b0, 32'hA00, 1'b0, 1'b0, 8'd0, 8'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
